// File: rtl/conv_axil_pkg.sv
// conv_axil_pkg: response codes, register bit indices, FSM states and address decode for the conv register bank
package conv_axil_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int CTRL_START = 0;
    localparam int CTRL_AUTO  = 1;
    localparam int CTRL_IE    = 2;
    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_ERR   = 2;
    typedef enum logic {W_IDLE, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;
    typedef enum logic [2:0] {REG_IN, REG_OUT, REG_CTRL, REG_STATUS, REG_ILLEGAL} region_e;
    typedef struct packed {
        region_e     region;
        logic [15:0] idx;
    } reg_sel_t;
    function automatic reg_sel_t decode_word(input int w, input int n_in, input int n_out);
        reg_sel_t s;
        s.idx    = 16'(w < n_in ? w : w - n_in);
        s.region = w < n_in ? REG_IN :
                   w < n_in + n_out ? REG_OUT :
                   w == n_in + n_out ? REG_CTRL :
                   w == n_in + n_out + 1 ? REG_STATUS : REG_ILLEGAL;
        return s;
    endfunction
endpackage

// File: rtl/axil_slave_chan.sv
// axil_slave_chan: AXI4-Lite write/read handshake FSMs presenting a simple register access port
module axil_slave_chan
    import conv_axil_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W/8-1:0] wr_strb,
    input  logic [1:0]          wr_resp,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   rd_data,
    input  logic [1:0]          rd_resp
);
    wr_state_e w_state, w_next;
    rd_state_e r_state, r_next;
    logic aw_held, w_held;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [DATA_W/8-1:0] w_strb_q;

    // a held beat takes priority over the live channel so AW and W may arrive in either order
    always_comb begin
        awready = w_state == W_IDLE && !aw_held;
        wready  = w_state == W_IDLE && !w_held;
        bvalid  = w_state == W_RESP;
        wr_addr = aw_held ? aw_addr_q : awaddr;
        wr_data = w_held ? w_data_q : wdata;
        wr_strb = w_held ? w_strb_q : wstrb;
        wr_en   = w_state == W_IDLE && (aw_held || awvalid) && (w_held || wvalid);
        w_next  = wr_en ? W_RESP : (bvalid && bready) ? W_IDLE : w_state;
        arready = r_state == R_IDLE;
        rvalid  = r_state == R_DATA;
        rd_en   = arready && arvalid;
        rd_addr = araddr;
        r_next  = rd_en ? R_DATA : (rvalid && rready) ? R_IDLE : r_state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            r_state   <= R_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp     <= RESP_OKAY;
            rresp     <= RESP_OKAY;
            rdata     <= '0;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            aw_held <= !wr_en && (aw_held || (awready && awvalid));
            w_held  <= !wr_en && (w_held || (wready && wvalid));
            if (awready && awvalid) aw_addr_q <= awaddr;
            if (wready && wvalid) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (wr_en) bresp <= wr_resp;
            if (rd_en) begin
                rdata <= rd_data;
                rresp <= rd_resp;
            end
        end
    end
endmodule

// File: rtl/conv_axil_regbank.sv
// conv_axil_regbank: AXI4-Lite operand/result register bank with start/done handshake to the convolution core
module conv_axil_regbank
    import conv_axil_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [ADDR_W-1:0]         S_AXI_AWADDR,
    input  logic [2:0]                S_AXI_AWPROT,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,
    input  logic [DATA_W-1:0]         S_AXI_WDATA,
    input  logic [DATA_W/8-1:0]       S_AXI_WSTRB,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,
    output logic [1:0]                S_AXI_BRESP,
    output logic                      S_AXI_BVALID,
    input  logic                      S_AXI_BREADY,
    input  logic [ADDR_W-1:0]         S_AXI_ARADDR,
    input  logic [2:0]                S_AXI_ARPROT,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,
    output logic [DATA_W-1:0]         S_AXI_RDATA,
    output logic [1:0]                S_AXI_RRESP,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY,
    output logic [NUM_IN*DATA_W-1:0]  core_in,
    output logic                      core_start,
    input  logic                      core_done,
    input  logic [NUM_OUT*DATA_W-1:0] core_out,
    output logic                      irq
);
    localparam int B  = DATA_W / 8;
    localparam int LB = $clog2(B);

    logic wr_en, rd_en;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] wr_data, rd_data;
    logic [B-1:0] wr_strb;
    logic [1:0] wr_resp, rd_resp;
    logic [DATA_W-1:0] in_q [NUM_IN];
    logic [DATA_W-1:0] out_q [NUM_OUT];
    logic auto_q, ie_q, busy_q, done_q, err_q, start_q;
    logic in_wr, st_wr, start_req, start_ok, start_err;
    reg_sel_t ws, rs;
    logic unused;

    // reads have no side effects, so rd_en is only needed inside the channel
    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, rd_en};

    axil_slave_chan #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_chan (
        .clk(ACLK), .rst_n(ARESETN),
        .awaddr(S_AXI_AWADDR), .awvalid(S_AXI_AWVALID), .awready(S_AXI_AWREADY),
        .wdata(S_AXI_WDATA), .wstrb(S_AXI_WSTRB), .wvalid(S_AXI_WVALID), .wready(S_AXI_WREADY),
        .bresp(S_AXI_BRESP), .bvalid(S_AXI_BVALID), .bready(S_AXI_BREADY),
        .araddr(S_AXI_ARADDR), .arvalid(S_AXI_ARVALID), .arready(S_AXI_ARREADY),
        .rdata(S_AXI_RDATA), .rresp(S_AXI_RRESP), .rvalid(S_AXI_RVALID), .rready(S_AXI_RREADY),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .wr_resp(wr_resp),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_resp(rd_resp)
    );

    // core_done retires the running job before any start in the same cycle is judged
    always_comb begin
        ws        = decode_word(int'(wr_addr >> LB), NUM_IN, NUM_OUT);
        rs        = decode_word(int'(rd_addr >> LB), NUM_IN, NUM_OUT);
        in_wr     = wr_en && ws.region == REG_IN && !busy_q;
        st_wr     = wr_en && ws.region == REG_STATUS;
        wr_resp   = (ws.region == REG_CTRL || ws.region == REG_STATUS ||
                     (ws.region == REG_IN && !busy_q)) ? RESP_OKAY : RESP_SLVERR;
        start_req = (wr_en && ws.region == REG_CTRL && wr_data[CTRL_START]) ||
                    (in_wr && auto_q && ws.idx == 16'(NUM_IN - 1));
        start_ok  = start_req && !(busy_q && !core_done);
        start_err = start_req && busy_q && !core_done;
        rd_resp   = rs.region == REG_ILLEGAL ? RESP_SLVERR : RESP_OKAY;
        rd_data   = '0;
        for (int k = 0; k < NUM_IN; k++)
            if (rs.region == REG_IN && rs.idx == 16'(k)) rd_data = in_q[k];
        for (int k = 0; k < NUM_OUT; k++)
            if (rs.region == REG_OUT && rs.idx == 16'(k)) rd_data = out_q[k];
        if (rs.region == REG_CTRL) begin
            rd_data[CTRL_AUTO] = auto_q;
            rd_data[CTRL_IE]   = ie_q;
        end
        if (rs.region == REG_STATUS) begin
            rd_data[STAT_BUSY] = busy_q;
            rd_data[STAT_DONE] = done_q;
            rd_data[STAT_ERR]  = err_q;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            for (int k = 0; k < NUM_IN; k++) in_q[k] <= '0;
            for (int k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
            auto_q  <= 1'b0;
            ie_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_IN; k++)
                for (int b = 0; b < B; b++)
                    if (in_wr && ws.idx == 16'(k) && wr_strb[b]) in_q[k][8*b +: 8] <= wr_data[8*b +: 8];
            if (core_done)
                for (int k = 0; k < NUM_OUT; k++) out_q[k] <= core_out[k*DATA_W +: DATA_W];
            if (wr_en && ws.region == REG_CTRL) begin
                auto_q <= wr_data[CTRL_AUTO];
                ie_q   <= wr_data[CTRL_IE];
            end
            start_q <= start_ok;
            busy_q  <= start_ok || (busy_q && !core_done);
            done_q  <= !start_ok && (core_done || (done_q && !(st_wr && wr_data[STAT_DONE])));
            err_q   <= start_err || (err_q && !(st_wr && wr_data[STAT_ERR]));
        end
    end

    for (genvar g = 0; g < NUM_IN; g++) begin : g_in
        assign core_in[g*DATA_W +: DATA_W] = in_q[g];
    end

    assign core_start = start_q;
    assign irq        = done_q & ie_q;
endmodule
